// File: rtl/fb_pkg.sv
// Shared constants and type definitions for the framebuffer arbiter slice.
// Imported by the arbiter top and the clear-screen sequencer.
package fb_pkg;

  localparam int FB_ADDR_W     = 12;
  localparam int FB_DATA_W     = 16;
  localparam int FB_WORDS      = 4000;
  localparam int FB_LINE_WORDS = 20;

  // Who owns the access travelling down the response pipeline.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_HOST,
    OWN_CLR
  } owner_t;

  typedef enum logic {
    CLR_IDLE,
    CLR_FILL
  } clr_state_t;

endpackage

// File: rtl/fb_clear_seq.sv
// Clear-screen sequencer: walks every framebuffer word writing a latched fill value,
// advancing only on cycles where the arbiter grants it the RAM slot.
module fb_clear_seq
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int WORDS  = FB_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  input  logic              grant,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              done_q, last_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      addr_q  <= '0;
      value_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      done_q  <= last_write;
    end
  end

  // A start pulse during FILL is ignored so the fill value stays stable.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    value_d    = value_q;
    last_write = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (start) begin
          state_d = CLR_FILL;
          addr_d  = '0;
          value_d = value;
        end
      end
      CLR_FILL: begin
        if (grant) begin
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == LAST_ADDR) begin
            state_d    = CLR_IDLE;
            last_write = 1'b1;
          end
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign req  = (state_q == CLR_FILL);
  assign busy = (state_q == CLR_FILL);
  assign addr = addr_q;
  assign data = value_q;
  assign done = done_q;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display scan-out first, then a starving clear,
// then the host, then a pending clear; reads return on a fixed two-cycle pipeline.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int FB_WORDS     = 4000,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [DATA_W-1:0] host_wmask,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(FB_WORDS));
  endfunction

  logic              clr_req, clr_grant, host_grant, forced;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;
  logic [CNT_W-1:0]  starve_q;

  owner_t            sel_owner;
  logic              sel_rd, sel_we, sel_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, sel_wmask;

  owner_t            owner1, owner2;
  logic              rd1, rd2, inr1, inr2;

  fb_clear_seq #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .WORDS (FB_WORDS)
  ) u_clear (
    .clk  (clk),
    .rst  (rst),
    .start(clr_start),
    .value(clr_value),
    .grant(clr_grant),
    .req  (clr_req),
    .addr (clr_addr),
    .data (clr_data),
    .busy (clr_busy),
    .done (clr_done)
  );

  assign forced     = clr_busy && (starve_q == LIMIT);
  assign host_ready = !rst && !disp_req && !forced;
  assign host_grant = host_valid && host_ready;
  assign clr_grant  = !rst && !disp_req && clr_req && (forced || !host_valid);

  always_comb begin
    sel_owner = OWN_NONE;
    sel_rd    = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    if (disp_req) begin
      sel_owner = OWN_DISP;
      sel_rd    = 1'b1;
      sel_addr  = disp_addr;
    end else if (clr_grant) begin
      sel_owner = OWN_CLR;
      sel_we    = 1'b1;
      sel_addr  = clr_addr;
      sel_wdata = clr_data;
      sel_wmask = '1;
    end else if (host_grant) begin
      sel_owner = OWN_HOST;
      sel_rd    = !host_we;
      sel_we    = host_we;
      sel_addr  = host_addr;
      sel_wdata = host_wdata;
      sel_wmask = host_wmask;
    end
  end

  assign sel_ok = (sel_owner != OWN_NONE) && in_range(sel_addr);

  // Host wins only while the counter is below the limit, so no extra saturation test is needed there.
  always_ff @(posedge clk) begin
    if (rst || !clr_busy || clr_grant) begin
      starve_q <= '0;
    end else if (host_grant && (starve_q != LIMIT)) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      owner1    <= OWN_NONE;
      rd1       <= 1'b0;
      inr1      <= 1'b0;
      owner2    <= OWN_NONE;
      rd2       <= 1'b0;
      inr2      <= 1'b0;
    end else begin
      mem_en    <= sel_ok;
      mem_we    <= sel_ok && sel_we;
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
      mem_wmask <= sel_wmask;
      owner1    <= sel_owner;
      rd1       <= sel_rd;
      inr1      <= in_range(sel_addr);
      owner2    <= owner1;
      rd2       <= rd1;
      inr2      <= inr1;
    end
  end

  // Out-of-range reads still answer on time, but with zero instead of RAM data.
  assign disp_rvalid = rd2 && (owner2 == OWN_DISP);
  assign host_rvalid = rd2 && (owner2 == OWN_HOST);
  assign disp_rdata  = (disp_rvalid && inr2) ? mem_rdata : '0;
  assign host_rdata  = (host_rvalid && inr2) ? mem_rdata : '0;

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares the single-port 1-bpp framebuffer RAM (320x200 pixels, 16-pixel words, 4000 words) among three requesters.
- Requesters are the VGA scan-out fetch, the host/GPU draw port and an internal clear-screen sequencer.
- Scan-out has absolute priority because it has a hard timing deadline. The host and clear engine share the remaining slots, with anti-starvation for the clear engine.
- Sits between the VGA timing block, the drawing logic and the framebuffer RAM.

Parameters:
- ADDR_W, 12, framebuffer word address width
- DATA_W, 16, framebuffer word width (pixels per word)
- FB_WORDS, 4000, number of valid words (320/16 * 200)
- STARVE_LIMIT, 8, consecutive host-won cycles after which a pending clear write takes the next free slot

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- disp_req  in  1  scan-out read request; always accepted, no ready
- disp_addr  in  ADDR_W  scan-out word address
- disp_rvalid  out  1  scan-out read data valid
- disp_rdata  out  DATA_W  scan-out read data
- host_valid  in  1  host request valid
- host_ready  out  1  host request accepted this cycle
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_wmask  in  DATA_W  per-bit write enable
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- clr_start  in  1  pulse: start filling the framebuffer
- clr_value  in  DATA_W  fill word, sampled at clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when the last word is written
- mem_en  out  1  RAM access enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_wmask  out  DATA_W  RAM bit mask (registered)
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_en

Behaviour:
- Reset state:
  - All outputs are 0; host_ready is 0 during rst.
  - Clear FSM is IDLE, starvation counter is 0, read-owner pipeline is flushed.
- Per-cycle grant priority:
  - disp_req wins first.
  - Otherwise, a forced clear (counter == STARVE_LIMIT) wins.
  - Otherwise host_valid wins.
  - Otherwise a pending clear write wins.
  - Otherwise the slot is idle.
- host_ready is combinational: !rst && !disp_req && !(clr_busy && counter == STARVE_LIMIT). A handshake occurs when host_valid && host_ready.
- Timing:
  - Grant in cycle N; mem_* driven in N+1; read data on disp_rvalid / host_rvalid in N+2.
  - Latency is fixed and there is no backpressure on read data.
- An owner tag (NONE/DISP/HOST/CLR) and an in-range flag follow each access through a 2-stage pipeline. Each rvalid asserts only for the matching owner's reads. Writes produce no response.
- Out-of-range addresses (>= FB_WORDS):
  - mem_en stays 0.
  - Host and display reads still return rvalid at N+2 with rdata 0.
  - Host writes are accepted and dropped.
- Clear FSM, states IDLE and FILL:
  - IDLE -> FILL on clr_start: latch clr_value, clr_addr = 0, clr_busy = 1.
  - In FILL, each granted cycle issues a full-mask write of clr_value at clr_addr, then increments clr_addr.
  - When the write at FB_WORDS-1 is granted: go to IDLE, clr_busy = 0, clr_done pulses in the following cycle.
  - clr_start during FILL is ignored; clr_value is not re-sampled.
- Starvation counter:
  - Increments in each FILL cycle where the host wins the slot.
  - Saturates at STARVE_LIMIT.
  - Resets to 0 whenever the clear engine is granted or the FSM is IDLE.
  - Display-won cycles leave it unchanged.
- Simultaneous disp_req and forced clear: display wins. The clear stays forced until it is granted.
- rst mid-operation:
  - Aborts FILL with no clr_done.
  - Discards in-flight responses: no rvalid in the following cycles.
  - Drops mem_en the next cycle.
- Address and data widths pass through unchanged; no arithmetic beyond the clr_addr increment (ADDR_W bits, no wrap).

Decomposition:
- Package fb_pkg:
  - FB_ADDR_W, FB_DATA_W, FB_WORDS, FB_LINE_WORDS = 20.
  - Owner enum: OWN_NONE, OWN_DISP, OWN_HOST, OWN_CLR.
- Sub-module fb_clear_seq:
  - Contains the clear FSM, fill address counter and latched value.
  - Exposes req/grant/addr/data plus busy/done.
- Arbitration, starvation counter and response pipeline stay in fb_arbiter.

Test Plan:
- Display-only: disp_req every 2nd cycle, addr 0..19, RAM preloaded with addr -> mem_rdata → disp_rvalid exactly 2 cycles after each request, data == addr, host_ready low only in disp_req cycles.
- Host collision: host_valid write addr 5 data 0xA5A5 mask 0x00FF, asserted together with disp_req → host_ready=0 that cycle; write issues the next non-display cycle with mem_wmask=0x00FF; a later host read of 5 returns 0x00A5 over initial 0.
- Clear completion: clr_start, clr_value 0xFFFF, no other traffic → 4000 consecutive writes addr 0..3999, clr_busy high throughout, clr_done single pulse, then idle.
- Starvation: FILL with host_valid held continuously → exactly one clear write after every 8 host grants; clear finishes.
- Out-of-range: host read addr 4000 → mem_en stays 0; host_rvalid at N+2 with rdata 0. Host write addr 4095 → accepted, no RAM write.
- Reset mid-clear: rst at clear addr 100 with a host read in flight → no host_rvalid, no clr_done, clr_busy=0, mem_en=0 next cycle.
